// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared arbiter FSM states and idle-bus constants
package nes_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWNED    = 2'd1,
      HANDOVER = 2'd2
   } arb_state_e;

   // Idle bus: address and data all zero, read/not-write high
   localparam logic IDLE_BUS_FILL = 1'b0;
   localparam logic IDLE_BUS_R_NW = 1'b1;

endpackage

// File: rtl/cpu_bus_arb_wait_ctr.sv
// rtl/cpu_bus_arb_wait_ctr.sv - saturating per-master wait counter for starvation detection
module cpu_bus_arb_wait_ctr #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic req_in,
   input  logic gnt_in,
   output logic starve_out
);

   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!req_in || gnt_in)            cnt_d = '0;
      else if (cnt_q != CW'(MAX_WAIT))  cnt_d = cnt_q + 1'b1;
   end

   assign starve_out = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/cpu_bus_arb.sv
// rtl/cpu_bus_arb.sv - fixed-priority non-preemptive bus arbiter with 1-cycle handover
// Define CPU_BUS_ARB_STARVE_EN to add per-master starvation counters that override priority.
module cpu_bus_arb
   import nes_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int MAX_WAIT    = 255
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [NUM_MASTERS-1:0]        req_in,
   input  logic [NUM_MASTERS*ADDR_W-1:0] a_in,
   input  logic [NUM_MASTERS*DATA_W-1:0] d_in,
   input  logic [NUM_MASTERS-1:0]        r_nw_in,
   input  logic [DATA_W-1:0]             bus_d_in,
   output logic [NUM_MASTERS-1:0]        gnt_out,
   output logic [ADDR_W-1:0]             bus_a_out,
   output logic [DATA_W-1:0]             bus_d_out,
   output logic                          bus_r_nw_out,
   output logic [DATA_W-1:0]             rd_d_out,
   output logic [NUM_MASTERS-1:0]        starve_out
);

   localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_e              state_q, state_d;
   logic [OW-1:0]           owner_q, owner_d;
   logic [DATA_W-1:0]       rd_q, rd_d;
   logic [NUM_MASTERS-1:0]  starve;
   logic [NUM_MASTERS-1:0]  elig;
   logic [OW-1:0]           winner;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         owner_q <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rd_q    <= rd_d;
      end
   end

   // Starved requesters, if any, shadow everyone else; lowest index wins within the set
   always_comb begin
      elig = req_in;
      if (|(req_in & starve)) elig = req_in & starve;
      winner = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (elig[i]) winner = OW'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      unique case (state_q)
         IDLE: begin
            if (|req_in) begin
               state_d = OWNED;
               owner_d = winner;
            end
         end
         OWNED:    if (!req_in[owner_q]) state_d = HANDOVER;
         HANDOVER: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_out      = '0;
      bus_a_out    = {ADDR_W{IDLE_BUS_FILL}};
      bus_d_out    = {DATA_W{IDLE_BUS_FILL}};
      bus_r_nw_out = IDLE_BUS_R_NW;
      if (state_q == OWNED) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == OW'(i)) begin
               gnt_out[i]   = 1'b1;
               bus_a_out    = a_in[i*ADDR_W +: ADDR_W];
               bus_d_out    = d_in[i*DATA_W +: DATA_W];
               bus_r_nw_out = r_nw_in[i];
            end
         end
      end
   end

   always_comb begin
      rd_d = rd_q;
      if (state_q == OWNED && bus_r_nw_out) rd_d = bus_d_in;
   end

   assign rd_d_out = rd_q;

`ifdef CPU_BUS_ARB_STARVE_EN
   logic [NUM_MASTERS-1:0] grant_now;

   // Counters clear on the arbitration edge itself, so starve drops as the grant appears
   always_comb begin
      grant_now = gnt_out;
      if (state_q == IDLE && |req_in) grant_now[winner] = 1'b1;
   end

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_wait
      cpu_bus_arb_wait_ctr #(
         .MAX_WAIT (MAX_WAIT)
      ) u_wait_ctr (
         .clk_in     (clk_in),
         .rst_in     (rst_in),
         .req_in     (req_in[g]),
         .gnt_in     (grant_now[g]),
         .starve_out (starve[g])
      );
   end
`else
   assign starve = '0;
`endif

   assign starve_out = starve;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// tb/tb_cpu_bus_arb.sv - directed vector bench for cpu_bus_arb (either CPU_BUS_ARB_STARVE_EN build)
module tb_cpu_bus_arb;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [2:0]  req_in = '0;
   logic [47:0] a_in   = {16'h3003, 16'h2002, 16'h1000};
   logic [23:0] d_in   = {8'h33, 8'h22, 8'h11};
   logic [2:0]  r_nw_in = 3'b111;
   logic [7:0]  bus_d_in = '0;
   logic [2:0]  gnt_out;
   logic [15:0] bus_a_out;
   logic [7:0]  bus_d_out;
   logic        bus_r_nw_out;
   logic [7:0]  rd_d_out;
   logic [2:0]  starve_out;

   int n_vec = 0;
   int n_bad = 0;

   cpu_bus_arb #(
      .NUM_MASTERS (3),
      .ADDR_W      (16),
      .DATA_W      (8),
      .MAX_WAIT    (4)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .req_in       (req_in),
      .a_in         (a_in),
      .d_in         (d_in),
      .r_nw_in      (r_nw_in),
      .bus_d_in     (bus_d_in),
      .gnt_out      (gnt_out),
      .bus_a_out    (bus_a_out),
      .bus_d_out    (bus_d_out),
      .bus_r_nw_out (bus_r_nw_out),
      .rd_d_out     (rd_d_out),
      .starve_out   (starve_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  rnw;
      logic [7:0]  bd;
      logic [2:0]  gnt;
      logic [15:0] a;
      logic [7:0]  d;
      logic        rw;
      logic [7:0]  rd;
   } vec_t;

   typedef struct {
      logic [2:0] req;
      logic [2:0] gnt;
      logic [2:0] stv;
   } stv_t;

   vec_t vecs[12];
   stv_t svec[$];

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] snap();
      return {25'd0, gnt_out, bus_a_out, bus_d_out, bus_r_nw_out, rd_d_out, starve_out};
   endfunction

   function automatic logic [63:0] pack(input logic [2:0] g, input logic [15:0] a, input logic [7:0] d,
                                        input logic rw, input logic [7:0] rd, input logic [2:0] s);
      return {25'd0, g, a, d, rw, rd, s};
   endfunction

   initial begin
      //          rst  req     rnw     bd     gnt     a         d      rw    rd
      vecs[0]  = '{1'b1, 3'b000, 3'b111, 8'h00, 3'b000, 16'h0000, 8'h00, 1'b1, 8'h00};
      vecs[1]  = '{1'b0, 3'b110, 3'b111, 8'h80, 3'b010, 16'h2002, 8'h22, 1'b1, 8'h00};
      vecs[2]  = '{1'b0, 3'b010, 3'b111, 8'h80, 3'b010, 16'h2002, 8'h22, 1'b1, 8'h80};
      vecs[3]  = '{1'b0, 3'b010, 3'b101, 8'h55, 3'b010, 16'h2002, 8'h22, 1'b0, 8'h80};
      vecs[4]  = '{1'b0, 3'b100, 3'b101, 8'h55, 3'b000, 16'h0000, 8'h00, 1'b1, 8'h80};
      vecs[5]  = '{1'b0, 3'b100, 3'b011, 8'h55, 3'b000, 16'h0000, 8'h00, 1'b1, 8'h80};
      vecs[6]  = '{1'b0, 3'b100, 3'b011, 8'h55, 3'b100, 16'h3003, 8'h33, 1'b0, 8'h80};
      vecs[7]  = '{1'b0, 3'b100, 3'b011, 8'h55, 3'b100, 16'h3003, 8'h33, 1'b0, 8'h80};
      vecs[8]  = '{1'b0, 3'b101, 3'b011, 8'h55, 3'b100, 16'h3003, 8'h33, 1'b0, 8'h80};
      vecs[9]  = '{1'b0, 3'b001, 3'b011, 8'h55, 3'b000, 16'h0000, 8'h00, 1'b1, 8'h80};
      vecs[10] = '{1'b0, 3'b001, 3'b011, 8'h55, 3'b000, 16'h0000, 8'h00, 1'b1, 8'h80};
      vecs[11] = '{1'b0, 3'b001, 3'b011, 8'h55, 3'b001, 16'h1000, 8'h11, 1'b1, 8'h80};

`ifdef CPU_BUS_ARB_STARVE_EN
      svec.push_back('{3'b101, 3'b001, 3'b000});
      svec.push_back('{3'b100, 3'b000, 3'b000});
      svec.push_back('{3'b101, 3'b000, 3'b000});
      svec.push_back('{3'b101, 3'b001, 3'b100});
      svec.push_back('{3'b100, 3'b000, 3'b100});
      svec.push_back('{3'b101, 3'b000, 3'b100});
      svec.push_back('{3'b101, 3'b100, 3'b000});
      svec.push_back('{3'b101, 3'b100, 3'b000});
`else
      for (int k = 0; k < 12; k++) begin
         svec.push_back('{(k % 3 == 1) ? 3'b100 : 3'b101,
                          (k % 3 == 0) ? 3'b001 : 3'b000, 3'b000});
      end
`endif

      #1;
      for (int i = 0; i < 12; i++) begin
         rst_in   = vecs[i].rst;
         req_in   = vecs[i].req;
         r_nw_in  = vecs[i].rnw;
         bus_d_in = vecs[i].bd;
         tick();
         check($sformatf("vec%0d", i), snap(),
               pack(vecs[i].gnt, vecs[i].a, vecs[i].d, vecs[i].rw, vecs[i].rd, 3'b000));
         if (!$onehot0(gnt_out)) check($sformatf("vec%0d_onehot", i), 64'(gnt_out), 64'd0);
      end

      // Asynchronous reset mid-ownership: outputs must clear before any clock edge
      #2;
      rst_in = 1'b1;
      #1;
      check("async_rst", snap(), pack(3'b000, 16'h0000, 8'h00, 1'b1, 8'h00, 3'b000));
      #1;
      rst_in  = 1'b0;
      req_in  = 3'b001;
      r_nw_in = 3'b111;
      tick();
      check("resume_after_rst", snap(), pack(3'b001, 16'h1000, 8'h11, 1'b1, 8'h00, 3'b000));

      rst_in = 1'b1;
      req_in = 3'b000;
      tick();
      rst_in = 1'b0;
      for (int k = 0; k < svec.size(); k++) begin
         req_in = svec[k].req;
         tick();
         check($sformatf("starve_e%0d", k + 1), {58'd0, gnt_out, starve_out},
               {58'd0, svec[k].gnt, svec[k].stv});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_arb.md
CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of bus masters; index 0 is highest priority.
REQ-002 SHALL have parameter ADDR_W, default 16, address bus width.
REQ-003 SHALL have parameter DATA_W, default 8, data bus width.
REQ-004 SHALL have parameter MAX_WAIT, default 255, starvation threshold in cycles; it is used only with the Configuration feature.
REQ-005 SHALL have port clk_in, input, 1, the single system clock.
REQ-006 SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port req_in, input, NUM_MASTERS, per-master bus request.
REQ-008 SHALL have port a_in, input, NUM_MASTERS*ADDR_W, per-master address; master i occupies slice [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port d_in, input, NUM_MASTERS*DATA_W, per-master write data, packed the same way as a_in.
REQ-010 SHALL have port r_nw_in, input, NUM_MASTERS, per-master read/not-write.
REQ-011 SHALL have port bus_d_in, input, DATA_W, the wired-OR read data returned by the slaves.
REQ-012 SHALL have port gnt_out, output, NUM_MASTERS, one-hot or zero grant; it acts as the per-master ready.
REQ-013 SHALL have port bus_a_out, output, ADDR_W, the shared bus address.
REQ-014 SHALL have port bus_d_out, output, DATA_W, the shared bus write data.
REQ-015 SHALL have port bus_r_nw_out, output, 1, the shared bus read/not-write.
REQ-016 SHALL have port rd_d_out, output, DATA_W, the registered read data captured for the current owner.
REQ-017 SHALL have port starve_out, output, NUM_MASTERS, per-master starvation flag.

Function
REQ-018 SHALL implement FSM states IDLE, OWNED and HANDOVER.
REQ-019 SHALL, in IDLE with any req_in asserted, register the owner at the clock edge and assert that owner's gnt_out in the next cycle (1-cycle grant latency).
REQ-020 SHALL, when several requests are simultaneous, grant the lowest index, unless the starvation rule in REQ-030 applies.
REQ-021 SHALL, in OWNED, hold the grant for as long as the owner's req_in stays high; there is no preemption, including by a higher-priority master.
REQ-022 SHALL, when the owner deasserts req_in in OWNED, clear gnt_out at the next edge and enter HANDOVER for exactly one cycle, then return to IDLE.
REQ-023 SHALL, in IDLE and HANDOVER, drive an idle bus: bus_a_out=0, bus_d_out=0, bus_r_nw_out=1.
REQ-024 SHALL, in OWNED, drive bus_a_out, bus_d_out and bus_r_nw_out combinationally from the owner's slices, selected by the registered owner index.
REQ-025 SHALL, in OWNED with the owner's bus_r_nw_out=1, capture bus_d_in into rd_d_out at each clock edge; rd_d_out holds its value otherwise.
REQ-026 SHALL ignore the owner's write data and address while gnt_out is low.
REQ-027 SHALL keep gnt_out at most one-hot in every cycle.

Reset
REQ-028 SHALL, while rst_in is high and at any point mid-transaction: set the FSM to IDLE, owner to 0, gnt_out=0, rd_d_out=0, starve_out=0, all wait counters to 0, and drive the idle bus values.
REQ-029 SHALL arbitrate normally starting from the first clock edge after rst_in deasserts.

Configuration
REQ-030 SHALL, with CPU_BUS_ARB_STARVE_EN defined, keep a saturating wait counter per master. The counter increments on each cycle that master's req_in is high and it is not granted, and clears on grant or when req_in drops. starve_out[i] is 1 while counter i equals MAX_WAIT. At arbitration, starved masters win over non-starved ones, and ties among starved masters go to the lowest index.
REQ-031 SHALL, without CPU_BUS_ARB_STARVE_EN, implement pure fixed priority with no counters, and tie starve_out to 0.

Structure
REQ-032 SHALL place the FSM state enum and the idle-bus constants in shared package nes_bus_pkg.
REQ-033 SHALL implement the per-master counter as sub-module cpu_bus_arb_wait_ctr, instantiated NUM_MASTERS times and only when the macro is defined.

Verification
REQ-034 SHALL cover: req_in=3'b110 from reset -> gnt_out=3'b010 one cycle later; bus_a_out equals master 1's address.
REQ-035 SHALL cover: master 2 owns the bus and master 0 raises req -> master 2 keeps the grant; after master 2 drops req, one HANDOVER cycle with bus_r_nw_out=1 and gnt_out=0, then gnt_out=3'b001.
REQ-036 SHALL cover: owner reads at address 0x2002 with bus_d_in=0x80 -> rd_d_out=0x80 after the edge; a subsequent write leaves rd_d_out at 0x80.
REQ-037 SHALL cover: rst_in pulsed mid-OWNED -> gnt_out=0, bus_r_nw_out=1 and rd_d_out=0 immediately, without waiting for a clock edge.
REQ-038 SHALL cover: with the macro defined and MAX_WAIT=4, master 0 continually re-requests while master 2 requests continuously -> starve_out[2]=1 once its counter reaches 4; master 2 wins the next arbitration and its counter clears on grant.
REQ-039 SHALL cover: without the macro, the same stimulus -> master 2 is never granted and starve_out stays 0.
